// File: rtl/score_display_scan_if.sv
// Score/display bundle between the score tracker side and the display scanner.
interface score_display_scan_if;
   logic [3:0] left_tens;
   logic [3:0] left_ones;
   logic [3:0] right_tens;
   logic [3:0] right_ones;
   logic       lz_en;
   logic       sep_en;
   logic [7:0] segments;
   logic [3:0] anodes;
   logic       flashing;

   modport master (
      output left_tens, left_ones, right_tens, right_ones, lz_en, sep_en,
      input  segments, anodes, flashing
   );

   modport slave (
      input  left_tens, left_ones, right_tens, right_ones, lz_en, sep_en,
      output segments, anodes, flashing
   );
endinterface

// File: rtl/score_display_scan.sv
// Four-digit multiplexed seven-segment scanner for two BCD scores, with
// ghosting guard, leading-zero blanking and a flash sequence on score change.
module score_display_scan #(
   parameter int unsigned REFRESH_BITS = 16,
   parameter int unsigned GUARD_CYCLES = 16,
   parameter int unsigned FLASH_HALF   = 12,
   parameter int unsigned FLASH_PHASES = 6
) (
   input  logic                 clk25,
   input  logic                 reset,
   score_display_scan_if.slave  bus
);

   localparam int unsigned SLOT_BITS = REFRESH_BITS - 2;
   localparam int unsigned PHASE_W   = $clog2(FLASH_PHASES + 1);
   localparam int unsigned FRAME_W   = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_FLASH = 1'b1;

   logic [REFRESH_BITS-1:0] r_refresh_cnt;
   logic [15:0]             r_snap;
   logic [0:0]              r_state;
   logic [PHASE_W-1:0]      r_phase;
   logic [FRAME_W-1:0]      r_frame;
   logic                    r_flashing;
   logic [7:0]              r_segments;
   logic [3:0]              r_anodes;

   logic [1:0]              w_idx;
   logic [SLOT_BITS-1:0]    w_slot_pos;
   logic                    w_frame_tick;
   logic                    w_guard;
   logic [15:0]             w_digits;
   logic                    w_change;
   logic                    w_dark;
   logic [0:0]              w_state_nxt;
   logic [PHASE_W-1:0]      w_phase_nxt;
   logic [FRAME_W-1:0]      w_frame_nxt;
   logic [3:0]              w_digit;
   logic                    w_is_tens;
   logic [7:0]              w_seg_nxt;
   logic [3:0]              w_an_nxt;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b0111111;
      endcase
   endfunction

   assign w_idx        = r_refresh_cnt[REFRESH_BITS-1 -: 2];
   assign w_slot_pos   = r_refresh_cnt[SLOT_BITS-1:0];
   assign w_frame_tick = &r_refresh_cnt;
   assign w_guard      = w_slot_pos < SLOT_BITS'(GUARD_CYCLES);
   assign w_digits     = {bus.left_tens, bus.left_ones, bus.right_tens, bus.right_ones};
   assign w_change     = w_digits != r_snap;
   assign w_dark       = (r_state == ST_FLASH) && r_phase[0];

   // Snapshot follows inputs even in reset so a score present at reset is not a change.
   always_ff @(posedge clk25) begin
      if (reset) begin
         r_refresh_cnt <= '0;
         r_snap        <= w_digits;
      end else begin
         r_refresh_cnt <= r_refresh_cnt + REFRESH_BITS'(1);
         r_snap        <= w_digits;
      end
   end

   always_ff @(posedge clk25) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_phase    <= '0;
         r_frame    <= '0;
         r_flashing <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_phase    <= w_phase_nxt;
         r_frame    <= w_frame_nxt;
         r_flashing <= (w_state_nxt == ST_FLASH);
      end
   end

   // Change detect outranks the frame tick, so a change always restarts the sequence.
   always_comb begin
      w_state_nxt = r_state;
      w_phase_nxt = r_phase;
      w_frame_nxt = r_frame;
      if (w_change) begin
         w_state_nxt = ST_FLASH;
         w_phase_nxt = PHASE_W'(FLASH_PHASES);
         w_frame_nxt = '0;
      end else begin
         case (r_state)
            ST_FLASH: begin
               if (w_frame_tick) begin
                  if (r_frame == FRAME_W'(FLASH_HALF - 1)) begin
                     w_frame_nxt = '0;
                     w_phase_nxt = r_phase - PHASE_W'(1);
                     if (r_phase == PHASE_W'(1)) begin
                        w_state_nxt = ST_IDLE;
                     end
                  end else begin
                     w_frame_nxt = r_frame + FRAME_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_digit   = bus.right_ones;
      w_is_tens = 1'b0;
      case (w_idx)
         2'd0: begin w_digit = bus.right_ones; w_is_tens = 1'b0; end
         2'd1: begin w_digit = bus.right_tens; w_is_tens = 1'b1; end
         2'd2: begin w_digit = bus.left_ones;  w_is_tens = 1'b0; end
         default: begin w_digit = bus.left_tens; w_is_tens = 1'b1; end
      endcase

      w_seg_nxt = {1'b1, seg7(w_digit)};
      if ((w_idx == 2'd2) && bus.sep_en && !w_guard) begin
         w_seg_nxt[7] = 1'b0;
      end
      if (w_is_tens && bus.lz_en && (w_digit == 4'd0)) begin
         w_seg_nxt = 8'hFF;
      end
      if (w_dark) begin
         w_seg_nxt = 8'hFF;
      end

      w_an_nxt = ~(4'b0001 << w_idx);
      if (w_guard || w_dark) begin
         w_an_nxt = 4'hF;
      end
   end

   always_ff @(posedge clk25) begin
      if (reset) begin
         r_segments <= 8'hFF;
         r_anodes   <= 4'hF;
      end else begin
         r_segments <= w_seg_nxt;
         r_anodes   <= w_an_nxt;
      end
   end

   assign bus.segments = r_segments;
   assign bus.anodes   = r_anodes;
   assign bus.flashing = r_flashing;

endmodule

// File: tb/tb_score_display_scan.sv
// Directed bench for score_display_scan with a short refresh period.
module tb_score_display_scan;

   logic clk25 = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad   = 0;
   int   tb_cnt = 0;
   int   vis    = -1;

   logic [3:0] an_exp [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   score_display_scan_if bus();

   score_display_scan #(
      .REFRESH_BITS(6),
      .GUARD_CYCLES(2),
      .FLASH_HALF  (2),
      .FLASH_PHASES(4)
   ) dut (
      .clk25(clk25),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk25 = ~clk25;

   // Refresh count whose value the outputs currently display (one edge behind).
   always @(posedge clk25) begin
      if (reset) begin
         tb_cnt = 0;
         vis    = -1;
      end else begin
         vis    = tb_cnt;
         tb_cnt = tb_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic goto(input int target);
      bit hit = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk25);
         if (vis == target) begin
            hit = 1;
            break;
         end
      end
      if (!hit) chk("timeout", 32'(vis), 32'(target));
   endtask

   task automatic set_digits(input logic [3:0] lt, input logic [3:0] lo,
                             input logic [3:0] rt, input logic [3:0] ro);
      bus.left_tens  = lt;
      bus.left_ones  = lo;
      bus.right_tens = rt;
      bus.right_ones = ro;
   endtask

   task automatic do_reset(input logic [3:0] lt, input logic [3:0] lo,
                           input logic [3:0] rt, input logic [3:0] ro,
                           input logic lz, input logic sep);
      reset = 1'b1;
      set_digits(lt, lo, rt, ro);
      bus.lz_en  = lz;
      bus.sep_en = sep;
      repeat (3) @(negedge clk25);
      reset = 1'b0;
   endtask

   task automatic chk_slot(input string tag, input int frame, input int s, input logic [7:0] seg);
      goto(frame * 64 + s * 16 + 4);
      chk({tag, "_an"}, 32'(bus.anodes), 32'(an_exp[s]));
      chk({tag, "_seg"}, 32'(bus.segments), 32'(seg));
   endtask

   initial begin
      logic [7:0] scan_seg [4] = '{8'hA4, 8'hF9, 8'hB0, 8'hC0};

      // Reset values
      reset = 1'b1;
      set_digits(4'd0, 4'd3, 4'd1, 4'd2);
      bus.lz_en  = 1'b0;
      bus.sep_en = 1'b0;
      repeat (2) @(negedge clk25);
      chk("rst_seg", 32'(bus.segments), 32'h FF);
      chk("rst_an", 32'(bus.anodes), 32'hF);
      chk("rst_flash", 32'(bus.flashing), 32'h0);
      reset = 1'b0;

      // Basic scan with guard cycles
      for (int s = 0; s < 4; s++) begin
         goto(s * 16);
         chk("guard0", 32'(bus.anodes), 32'hF);
         goto(s * 16 + 1);
         chk("guard1", 32'(bus.anodes), 32'hF);
         goto(s * 16 + 2);
         chk("scan_an", 32'(bus.anodes), 32'(an_exp[s]));
         chk("scan_seg", 32'(bus.segments), 32'(scan_seg[s]));
         goto(s * 16 + 15);
         chk("scan_end", 32'(bus.anodes), 32'(an_exp[s]));
         chk("scan_fl", 32'(bus.flashing), 32'h0);
      end

      // Leading-zero blanking
      do_reset(4'd0, 4'd3, 4'd0, 4'd2, 1'b1, 1'b0);
      chk_slot("lz0", 0, 0, 8'hA4);
      chk_slot("lz1", 0, 1, 8'hFF);
      chk_slot("lz2", 0, 2, 8'hB0);
      chk_slot("lz3", 0, 3, 8'hFF);

      // Separator dot and dash glyph
      do_reset(4'd0, 4'd3, 4'd1, 4'd2, 1'b0, 1'b1);
      chk_slot("sep0", 0, 0, 8'hA4);
      chk_slot("sep2", 0, 2, 8'h30);
      chk_slot("sep3", 0, 3, 8'hC0);
      do_reset(4'd0, 4'hB, 4'd1, 4'hB, 1'b0, 1'b1);
      chk_slot("dash0", 0, 0, 8'hBF);
      chk_slot("dash1", 0, 1, 8'hF9);
      chk_slot("dash2", 0, 2, 8'h3F);

      // Flash sequence on a single change
      do_reset(4'd0, 4'd3, 4'd1, 4'd2, 1'b0, 1'b0);
      goto(20);
      chk("pre_flash", 32'(bus.flashing), 32'h0);
      bus.right_ones = 4'd3;
      goto(21);
      chk("flash_up", 32'(bus.flashing), 32'h1);
      goto(64 + 34);
      chk("ph4_an", 32'(bus.anodes), 32'(4'b1011));
      chk("ph4_fl", 32'(bus.flashing), 32'h1);
      goto(128 + 34);
      chk("ph3a_an", 32'(bus.anodes), 32'hF);
      goto(192 + 50);
      chk("ph3b_an", 32'(bus.anodes), 32'hF);
      goto(256 + 34);
      chk("ph2_an", 32'(bus.anodes), 32'(4'b1011));
      chk("ph2_seg", 32'(bus.segments), 32'hB0);
      goto(320 + 2);
      chk("ph2_an0", 32'(bus.anodes), 32'(4'b1110));
      chk("ph2_seg0", 32'(bus.segments), 32'hB0);
      goto(384 + 34);
      chk("ph1a_an", 32'(bus.anodes), 32'hF);
      goto(448 + 50);
      chk("ph1b_an", 32'(bus.anodes), 32'hF);
      goto(448 + 62);
      chk("fl_last", 32'(bus.flashing), 32'h1);
      goto(448 + 63);
      chk("fl_drop", 32'(bus.flashing), 32'h0);
      goto(512 + 34);
      chk("post_an", 32'(bus.anodes), 32'(4'b1011));
      chk("post_fl", 32'(bus.flashing), 32'h0);

      // Restart during a dark phase, then reset mid-flash
      do_reset(4'd0, 4'd3, 4'd1, 4'd3, 1'b0, 1'b0);
      goto(5);
      bus.right_ones = 4'd4;
      goto(128 + 20);
      chk("rs_dark", 32'(bus.anodes), 32'hF);
      bus.right_ones = 4'd5;
      goto(128 + 34);
      chk("rs_norm_a", 32'(bus.anodes), 32'(4'b1011));
      chk("rs_fl", 32'(bus.flashing), 32'h1);
      goto(192 + 34);
      chk("rs_norm_b", 32'(bus.anodes), 32'(4'b1011));
      goto(256 + 34);
      chk("rs_dark2", 32'(bus.anodes), 32'hF);
      goto(256 + 40);
      reset = 1'b1;
      @(negedge clk25);
      chk("mid_rst_fl", 32'(bus.flashing), 32'h0);
      chk("mid_rst_an", 32'(bus.anodes), 32'hF);
      chk("mid_rst_seg", 32'(bus.segments), 32'hFF);
      @(negedge clk25);
      reset = 1'b0;
      goto(64 + 34);
      chk("after_an", 32'(bus.anodes), 32'(4'b1011));
      chk("after_seg", 32'(bus.segments), 32'hB0);
      chk("after_fl", 32'(bus.flashing), 32'h0);
      goto(192 + 34);
      chk("after_an2", 32'(bus.anodes), 32'(4'b1011));
      chk("after_fl2", 32'(bus.flashing), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/score_display_scan.md
Name: score_display_scan

Overview:
- Downstream consumer of the score tracker: takes two 2-digit BCD scores (left and right player) and drives a 4-digit, common-anode, multiplexed seven-segment display.
- Scans the digits at a fixed refresh rate and inserts a ghosting guard at the start of each digit slot.
- Optionally blanks leading zeros.
- Flashes the whole display for a fixed number of frames whenever any score digit changes.

Parameters:
- REFRESH_BITS, 16: width of the refresh counter. Top 2 bits select the digit. One slot is 2^(REFRESH_BITS-2) cycles; a frame is 2^REFRESH_BITS cycles (about 2.6 ms at 25 MHz).
- GUARD_CYCLES, 16: cycles at the start of each slot with all anodes off. Must be less than 2^(REFRESH_BITS-2).
- FLASH_HALF, 12: frames per flash phase.
- FLASH_PHASES, 6: number of phases per flash sequence. Must be even.

Ports:
- clk25, in, 1: 25 MHz system clock.
- reset, in, 1: synchronous, active-high.
- left_tens, in, 4: BCD tens digit, left player.
- left_ones, in, 4: BCD ones digit, left player.
- right_tens, in, 4: BCD tens digit, right player.
- right_ones, in, 4: BCD ones digit, right player.
- lz_en, in, 1: 1 = blank a tens digit when it is 0.
- sep_en, in, 1: 1 = light the decimal point on digit slot 2 (score separator).
- segments, out, 8: {dp,g,f,e,d,c,b,a}, active-low, registered.
- anodes, out, 4: active-low digit enables, registered.
- flashing, out, 1: high while a flash sequence is in progress, registered.

Behaviour:
- Reset values:
  - refresh_cnt = 0, segments = 8'hFF, anodes = 4'hF, flashing = 0.
  - Phase and frame counters = 0.
  - The snapshot register loads the current input digits during reset, so a non-zero score present at reset does not trigger a flash.
- Refresh counter:
  - Increments every clk25 and wraps modulo 2^REFRESH_BITS.
  - idx = refresh_cnt[REFRESH_BITS-1:REFRESH_BITS-2].
  - frame_tick is asserted for one cycle when refresh_cnt is all ones.
- Slot mapping:
  - idx 0 = right_ones, anodes[0].
  - idx 1 = right_tens, anodes[1].
  - idx 2 = left_ones, anodes[2].
  - idx 3 = left_tens, anodes[3].
- Guard: when the low REFRESH_BITS-2 bits are less than GUARD_CYCLES, anodes = 4'hF. Otherwise only the selected anode is low.
- Decode (active-low, dp excluded):
  - 0..9 map to standard glyphs, e.g. 0=7'b1000000, 1=7'b1111001, 8=7'b0000000.
  - 10..15 show a dash (g only, 7'b0111111).
- Leading-zero blanking: with lz_en=1, a tens digit equal to 0 drives all segments off, including dp. Ones digits are never blanked.
- Decimal point: dp = 0 (lit) only on idx 2 when sep_en=1. Flash blanking and the guard override it.
- Latency: segments and anodes are registered. Output reflects idx and input digits sampled one cycle earlier.
- Change detect:
  - Each cycle the 16-bit input vector is compared with the snapshot, and the snapshot is updated.
  - A mismatch loads phase = FLASH_PHASES and frame_cnt = 0, and sets flashing = 1 on the next cycle.
  - A mismatch during an active flash restarts the sequence.
- Flash FSM, states IDLE and FLASH:
  - In FLASH, each frame_tick increments frame_cnt.
  - When frame_cnt = FLASH_HALF-1 at a frame_tick, frame_cnt clears and phase decrements.
  - When phase reaches 0, the FSM returns to IDLE and flashing drops.
  - While in FLASH with phase odd, anodes = 4'hF (display dark). With phase even, the display is normal.
  - With the default 6 phases: even, odd, even, odd, even, odd, giving 3 dark intervals.
- Simultaneous events: a change detect coinciding with a frame_tick takes priority (reload). A reset at any point aborts the flash and restores reset values in the same edge.

Test Plan:
- Setup: bench uses REFRESH_BITS=6, GUARD_CYCLES=2, FLASH_HALF=2, FLASH_PHASES=4.
- Reset, digits L=0,3 R=1,2, lz_en=0: after reset, anodes cycle 1110, 1101, 1011, 0111 every 16 cycles. Each slot starts with 2 cycles of 1111. Segments show 2, 1, 3, 0. flashing stays 0.
- lz_en=1 with left_tens=0, right_tens=0: slots 1 and 3 show segments=8'hFF. Slots 0 and 2 are unchanged.
- sep_en=1: segments[7]=0 only while anodes=1011. Set a digit to 4'hB: that slot shows 8'hBF, or 8'h3F on slot 2 with sep_en=1.
- Change right_ones 2 to 3 mid-frame: flashing=1 one cycle later. The display is dark during phases 3 and 1 (2 frames each) and normal during phases 4 and 2. flashing drops after 8 frames.
- Second change during the dark phase: phase reloads to 4 and the sequence restarts at normal. Reset asserted mid-flash: flashing=0, anodes=1111, segments=8'hFF next edge, and no flash after release.
